// File: rtl/if_fetch_pkg.sv
// Shared types, FSM state encodings and small address helpers for the
// instruction-fetch stage.
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam inst_addr_t ZERO_WORD = 32'h0000_0000;
    localparam inst_t      NOP_INST  = 32'h0000_0000;

    typedef enum logic [2:0] {
        IF_ST_IDLE  = 3'd0,
        IF_ST_FETCH = 3'd1,
        IF_ST_WAIT  = 3'd2,
        IF_ST_HOLD  = 3'd3,
        IF_ST_KILL  = 3'd4
    } if_state_e;

    // Sequential fetch address, wraps at 32 bits.
    function automatic inst_addr_t pc_next(input inst_addr_t pc);
        return pc + 32'd4;
    endfunction

    // True when an address is not word aligned.
    function automatic logic is_misaligned(input inst_addr_t addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // Force an address onto a word boundary.
    function automatic inst_addr_t align_word(input inst_addr_t addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Single-outstanding instruction-memory port: request/ready for the address
// phase, rvalid/rdata for the response phase.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic       req;
    inst_addr_t addr;
    logic       ready;
    logic       rvalid;
    inst_t      rdata;

    modport master (output req, output addr, input ready, input rvalid, input rdata);
    modport slave  (input req, input addr, output ready, output rvalid, output rdata);

endinterface

// File: rtl/if_fetch_buf.sv
// One-entry {vld, pc, inst} holding register between the memory response
// and the IF/ID register. An empty entry reads as pc=0 / inst=0 so the
// outputs can be presented directly as a bubble.
module if_fetch_buf
    import if_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  inst_addr_t wr_pc,
    input  inst_t      wr_inst,
    input  logic       consume,
    input  logic       flush,
    output logic       vld,
    output inst_addr_t pc,
    output inst_t      inst
);

    // Entry update: flush beats write, write beats consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld  <= 1'b0;
            pc   <= ZERO_WORD;
            inst <= NOP_INST;
        end else if (flush) begin
            vld  <= 1'b0;
            pc   <= ZERO_WORD;
            inst <= NOP_INST;
        end else if (wr) begin
            vld  <= 1'b1;
            pc   <= wr_pc;
            inst <= wr_inst;
        end else if (consume) begin
            vld  <= 1'b0;
            pc   <= ZERO_WORD;
            inst <= NOP_INST;
        end else begin
            vld  <= vld;
            pc   <= pc;
            inst <= inst;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, runs the single-outstanding
// memory handshake and feeds {if_pc, if_inst} to IF/ID from a 1-entry buffer.
// Optional feature macro: IF_MISALIGN_CHK_EN -- when defined, a redirect to a
// non-word-aligned target parks the stage and raises if_misalign instead of
// fetching; when undefined the target's low two bits are dropped.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter inst_addr_t RESET_PC = 32'h0000_0000
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       stall,
    input  logic             br,
    input  inst_addr_t       br_target,
    if_fetch_if.master       imem,
    output inst_addr_t       if_pc,
    output inst_t            if_inst,
    output logic             stallreq_if,
    output logic             if_misalign
);

    if_state_e  state_r;
    inst_addr_t fetch_pc_r;
    inst_addr_t req_pc_r;
    logic       misalign_r;

    logic       buf_vld_s;
    inst_addr_t buf_pc_s;
    inst_t      buf_inst_s;

    inst_addr_t target_s;
    logic       bad_tgt_s;
    logic       consume_s;
    logic       room_s;
    logic       req_s;
    logic       accept_s;
    logic       wr_s;
    logic       unused_s;

`ifdef IF_MISALIGN_CHK_EN
    assign target_s    = br_target;
    assign bad_tgt_s   = br && is_misaligned(br_target);
    assign if_misalign = misalign_r;
    assign unused_s    = ^stall[5:1];
`else
    assign target_s    = align_word(br_target);
    assign bad_tgt_s   = 1'b0;
    assign if_misalign = 1'b0;
    assign unused_s    = ^{stall[5:1], br_target[1:0]};
`endif

    // The entry leaves the buffer whenever IF/ID is not holding.
    assign consume_s = buf_vld_s && !stall[0];
    // A request is only issued if the buffer is guaranteed free by the time
    // the response can land; otherwise a stalled entry could be overwritten.
    assign room_s    = !buf_vld_s || !stall[0];
    assign req_s     = (state_r == IF_ST_FETCH) && room_s;
    assign accept_s  = req_s && imem.ready;
    assign wr_s      = (state_r == IF_ST_WAIT) && imem.rvalid && !br;

    assign imem.req    = req_s;
    assign imem.addr   = req_s ? fetch_pc_r : ZERO_WORD;
    assign stallreq_if = !buf_vld_s && (state_r != IF_ST_IDLE) && !br;
    assign if_pc       = buf_pc_s;
    assign if_inst     = buf_inst_s;

    if_fetch_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr_s),
        .wr_pc   (req_pc_r),
        .wr_inst (imem.rdata),
        .consume (consume_s),
        .flush   (br),
        .vld     (buf_vld_s),
        .pc      (buf_pc_s),
        .inst    (buf_inst_s)
    );

    // Fetch FSM and PC: redirect first, then the normal request/response walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IF_ST_IDLE;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= ZERO_WORD;
            misalign_r <= 1'b0;
        end else begin
            if (accept_s) begin
                req_pc_r <= fetch_pc_r;
            end else begin
                req_pc_r <= req_pc_r;
            end

            if (br) begin
                fetch_pc_r <= target_s;
                misalign_r <= bad_tgt_s;
                if (bad_tgt_s) begin
                    state_r <= IF_ST_IDLE;
                end else begin
                    case (state_r)
                        IF_ST_IDLE:  state_r <= IF_ST_FETCH;
                        IF_ST_FETCH: state_r <= accept_s ? IF_ST_KILL : IF_ST_FETCH;
                        IF_ST_WAIT:  state_r <= imem.rvalid ? IF_ST_FETCH : IF_ST_KILL;
                        IF_ST_HOLD:  state_r <= IF_ST_FETCH;
                        // The stale response still has to drain; if it lands
                        // in this very cycle there is nothing left to kill.
                        IF_ST_KILL:  state_r <= imem.rvalid ? IF_ST_FETCH : IF_ST_KILL;
                        default:     state_r <= IF_ST_IDLE;
                    endcase
                end
            end else begin
                misalign_r <= misalign_r;
                case (state_r)
                    IF_ST_IDLE: begin
                        fetch_pc_r <= fetch_pc_r;
                        state_r    <= misalign_r ? IF_ST_IDLE : IF_ST_FETCH;
                    end
                    IF_ST_FETCH: begin
                        if (accept_s) begin
                            fetch_pc_r <= pc_next(fetch_pc_r);
                            state_r    <= IF_ST_WAIT;
                        end else if (!room_s) begin
                            fetch_pc_r <= fetch_pc_r;
                            state_r    <= IF_ST_HOLD;
                        end else begin
                            fetch_pc_r <= fetch_pc_r;
                            state_r    <= IF_ST_FETCH;
                        end
                    end
                    IF_ST_WAIT: begin
                        fetch_pc_r <= fetch_pc_r;
                        if (imem.rvalid) begin
                            state_r <= (!buf_vld_s || consume_s) ? IF_ST_FETCH : IF_ST_HOLD;
                        end else begin
                            state_r <= IF_ST_WAIT;
                        end
                    end
                    IF_ST_HOLD: begin
                        fetch_pc_r <= fetch_pc_r;
                        state_r    <= consume_s ? IF_ST_FETCH : IF_ST_HOLD;
                    end
                    IF_ST_KILL: begin
                        fetch_pc_r <= fetch_pc_r;
                        state_r    <= imem.rvalid ? IF_ST_FETCH : IF_ST_KILL;
                    end
                    default: begin
                        fetch_pc_r <= fetch_pc_r;
                        state_r    <= IF_ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
